imu_poll_sched: RTL

- Periodic poll scheduler for the jb_imu SPI reader.
- Issues jb_imu start pulses at a fixed rate and watches done with a timeout; retries on timeout, enters fault after repeated timeouts.
- Latches the 9 IMU channels into a coherent snapshot with a valid strobe for the flight-control logic.
- Sits between jb_imu and the attitude/rate control loops, all in the 50 MHz clock domain.

---
 rtl/imu_poll_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imu_poll_sched.sv
// Periodic poll scheduler for the jb_imu SPI reader: timed starts, timeout/retry/fault, coherent snapshot.
// Optional IMU_POLL_SCHED_OVERRUN_EN adds overrun_count (ticks dropped while a transaction is running).
module imu_poll_sched #(
    parameter int PERIOD_CYCLES  = 250000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRY      = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           fault_clear,
    output logic           imu_start,
    input  logic           imu_done,
    input  logic [143:0]   imu_data,
    output logic [143:0]   sample,
    output logic           sample_valid,
    output logic [15:0]    sample_count,
    output logic [7:0]     timeout_count,
    output logic           busy,
`ifdef IMU_POLL_SCHED_OVERRUN_EN
    output logic [7:0]     overrun_count,
`endif
    output logic           fault
);
    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_LATCH, S_FAULT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_period_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [RW-1:0]   r_retry;
    logic            r_done_d;
    logic            r_done_rise;
    logic            r_sample_valid;
    logic [143:0]    r_sample;
    logic [15:0]     r_sample_count;
    logic [7:0]      r_timeout_count;
    logic            w_run;
    logic            w_tick;
    logic            w_timeout;
    logic            w_retry_ok;

    assign w_run      = enable && (r_state != S_FAULT);
    assign w_tick     = w_run && (r_period_cnt == PW'(PERIOD_CYCLES - 1));
    // A done edge in the same cycle as the last timeout count takes precedence.
    assign w_timeout  = (r_state == S_WAIT) && !r_done_rise &&
                        (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_retry_ok = (r_retry < RW'(MAX_RETRY));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (r_done_rise)     w_next = S_LATCH;
                else if (w_timeout)  w_next = w_retry_ok ? S_START : S_FAULT;
            end
            S_LATCH: w_next = S_IDLE;
            S_FAULT: if (fault_clear) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        imu_start = (r_state == S_START);
        busy      = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_LATCH);
        fault     = (r_state == S_FAULT);
    end

    // Timeout count is 0 in START and counts every clock spent in WAIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period_cnt    <= '0;
            r_to_cnt        <= '0;
            r_retry         <= '0;
            r_done_d        <= 1'b0;
            r_done_rise     <= 1'b0;
            r_timeout_count <= '0;
        end else begin
            if (!w_run || w_tick) r_period_cnt <= '0;
            else                  r_period_cnt <= r_period_cnt + 1'b1;

            r_to_cnt    <= (w_next == S_WAIT) ? r_to_cnt + 1'b1 : '0;
            r_done_d    <= imu_done;
            r_done_rise <= imu_done & ~r_done_d;

            if ((r_state == S_LATCH) || ((r_state == S_FAULT) && fault_clear))
                r_retry <= '0;
            else if (w_timeout && w_retry_ok)
                r_retry <= r_retry + 1'b1;

            if (w_timeout && (r_timeout_count != 8'hFF))
                r_timeout_count <= r_timeout_count + 1'b1;
        end
    end

    // Snapshot, count and strobe update together so the strobe always sees a complete sample.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sample       <= '0;
            r_sample_count <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= (r_state == S_LATCH);
            if (r_state == S_LATCH) begin
                r_sample       <= imu_data;
                r_sample_count <= r_sample_count + 1'b1;
            end
        end
    end

`ifdef IMU_POLL_SCHED_OVERRUN_EN
    logic [7:0] r_overrun_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun_count <= '0;
        end else if (w_tick && busy && (r_overrun_count != 8'hFF)) begin
            r_overrun_count <= r_overrun_count + 1'b1;
        end
    end

    assign overrun_count = r_overrun_count;
`endif

    assign sample        = r_sample;
    assign sample_valid  = r_sample_valid;
    assign sample_count  = r_sample_count;
    assign timeout_count = r_timeout_count;
endmodule
